seven_segment_reader: RTL and testbench

Receiving end of the multiplexed seven-segment display bus. It samples the active-low anode enables and the active-low segment/decimal-point lines driven toward the 4-digit display. It waits for each digit slot to settle, decodes the segment pattern back to a BCD digit, and assembles a full 4-digit frame. The block sits beside the display driver, so self-check logic and the testbench can read back what the alarm clock is actually showing.

---
 rtl/seven_segment_reader_if.sv | 21 ++
 rtl/seven_segment_reader.sv | 114 +++++++++++
 tb/tb_seven_segment_reader.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_reader_if.sv
// Display-bus tap: the anode/segment lines seen by the reader plus the decoded frame it reports.
interface seven_segment_reader_if;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        err_clr;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        err;

    modport master (
        output an, seg, err_clr,
        input  digits, dp, digit_valid, frame_done, err
    );

    modport slave (
        input  an, seg, err_clr,
        output digits, dp, digit_valid, frame_done, err
    );
endinterface

// File: rtl/seven_segment_reader.sv
// Samples the multiplexed 4-digit display lines, waits for each slot to settle,
// decodes the segment pattern back to BCD and assembles complete frames.
module seven_segment_reader #(
    parameter int SETTLE_CYCLES = 4
) (
    input logic clk,
    input logic rst,
    seven_segment_reader_if.slave bus
);
    // Counter holds the number of repeated samples; capture fires as it reaches SETTLE_CYCLES-1.
    localparam logic [7:0] CAP_CNT = 8'(SETTLE_CYCLES - 2);
    localparam logic [7:0] SAT_CNT = 8'(SETTLE_CYCLES - 1);

    logic [3:0]  an_prev;
    logic [7:0]  seg_prev;
    logic [7:0]  settle_cnt;
    logic [15:0] digits_q;
    logic [3:0]  dp_q;
    logic [3:0]  valid_q;
    logic        frame_done_q;
    logic        err_q;

    logic [2:0]  low_count;
    logic        sel_valid;
    logic        sel_conflict;
    logic        same;
    logic        capture;
    logic        pat_bad;
    logic [3:0]  pos_mask;
    logic [3:0]  dec_val;
    logic [3:0]  valid_next;
    logic        frame_last;

    always_comb begin
        low_count = 3'd0;
        for (int i = 0; i < 4; i++) begin
            low_count = low_count + {2'b00, ~bus.an[i]};
        end
        sel_valid    = (low_count == 3'd1);
        sel_conflict = (low_count >= 3'd2);
        same         = ({bus.an, bus.seg} == {an_prev, seg_prev});
        capture      = sel_valid && same && (settle_cnt == CAP_CNT);
        pos_mask     = ~bus.an;
        valid_next   = valid_q | pos_mask;
        frame_last   = (valid_next == 4'b1111);

        pat_bad = 1'b0;
        case (bus.seg[6:0])
            7'b1000000: dec_val = 4'd0;
            7'b1111001: dec_val = 4'd1;
            7'b0100100: dec_val = 4'd2;
            7'b0110000: dec_val = 4'd3;
            7'b0011001: dec_val = 4'd4;
            7'b0010010: dec_val = 4'd5;
            7'b0000010: dec_val = 4'd6;
            7'b1111000: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0010000: dec_val = 4'd9;
            7'b1111111: dec_val = 4'hF;
            default: begin
                dec_val = 4'hE;
                pat_bad = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_prev      <= 4'b1111;
            seg_prev     <= 8'hFF;
            settle_cnt   <= 8'd0;
            digits_q     <= 16'hFFFF;
            dp_q         <= 4'b0000;
            valid_q      <= 4'b0000;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            an_prev      <= bus.an;
            seg_prev     <= bus.seg;
            frame_done_q <= 1'b0;

            if (sel_valid && same) begin
                if (settle_cnt != SAT_CNT) settle_cnt <= settle_cnt + 8'd1;
            end else begin
                settle_cnt <= 8'd0;
            end

            if (capture) begin
                for (int i = 0; i < 4; i++) begin
                    if (pos_mask[i]) begin
                        digits_q[4*i +: 4] <= dec_val;
                        dp_q[i]            <= ~bus.seg[7];
                    end
                end
                if (frame_last) begin
                    valid_q      <= 4'b0000;
                    frame_done_q <= 1'b1;
                end else begin
                    valid_q <= valid_next;
                end
            end

            // A fresh error wins over a simultaneous clear.
            if (sel_conflict || (capture && pat_bad)) err_q <= 1'b1;
            else if (bus.err_clr)                      err_q <= 1'b0;
        end
    end

    assign bus.digits      = digits_q;
    assign bus.dp          = dp_q;
    assign bus.digit_valid = valid_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_seven_segment_reader.sv
// Scenario bench for seven_segment_reader: expected captures are queued as slots are
// driven and popped for comparison once the reader reports the capture.
module tb_seven_segment_reader;
    localparam int SETTLE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seven_segment_reader_if bus();

    seven_segment_reader #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         pos;
        logic [3:0] digit;
        logic       dp_on;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   fd_pulses = 0;

    logic [6:0] enc [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always @(negedge clk) if (bus.frame_done === 1'b1) fd_pulses++;

    function automatic logic [7:0] seg_of(input int d, input logic dp_on);
        return {~dp_on, enc[d]};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic present(input int pos, input logic [7:0] s);
        logic [3:0] one;
        one = 4'b0001;
        bus.an  = ~(one << pos);
        bus.seg = s;
    endtask

    task automatic go_idle();
        bus.an  = 4'b1111;
        bus.seg = 8'hFF;
    endtask

    // Bounded wait for a visible capture (digit_valid change or frame_done).
    task automatic wait_capture(input int max_cyc, output int cyc, output bit seen);
        logic [3:0] dv0;
        dv0  = bus.digit_valid;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < max_cyc) begin
            tick(1);
            cyc++;
            if (bus.digit_valid !== dv0 || bus.frame_done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic slot(input int pos, input logic [7:0] s, input logic [3:0] dig, input int hold,
                        output int cyc, output bit seen, output bit fd);
        exp_t e;
        present(pos, s);
        if (hold >= SETTLE) begin
            e.pos = pos; e.digit = dig; e.dp_on = ~s[7];
            sb.push_back(e);
        end
        wait_capture(hold, cyc, seen);
        fd = bus.frame_done;
        if (hold > cyc) tick(hold - cyc);
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.err_clr = 1'b0; go_idle();
        tick(2);
        checks++; if (bus.digits !== 16'hFFFF) begin failures++; $display("FAIL reset_digits: got %h expected ffff", bus.digits); end
        checks++; if (bus.dp !== 4'b0000) begin failures++; $display("FAIL reset_dp: got %b expected 0000", bus.dp); end
        checks++; if (bus.digit_valid !== 4'b0000) begin failures++; $display("FAIL reset_valid: got %b expected 0000", bus.digit_valid); end
        checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done: got %b expected 0", bus.frame_done); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", bus.err); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int cyc; bit seen, fd; exp_t e;
        slot(0, 8'b0011_0000, 4'd3, 4, cyc, seen, fd);
        e = sb.pop_front();
        checks++; if (!seen || cyc != SETTLE) begin failures++; $display("FAIL single_latency: got %0d seen=%0d expected %0d", cyc, seen, SETTLE); end
        checks++; if (bus.digits[4*e.pos +: 4] !== e.digit) begin failures++; $display("FAIL single_digit: got %h expected %h", bus.digits[4*e.pos +: 4], e.digit); end
        checks++; if (bus.dp[e.pos] !== e.dp_on) begin failures++; $display("FAIL single_dp: got %b expected %b", bus.dp[e.pos], e.dp_on); end
        checks++; if (bus.digit_valid !== 4'b0001) begin failures++; $display("FAIL single_valid: got %b expected 0001", bus.digit_valid); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL single_err: got %b expected 0", bus.err); end
        go_idle(); tick(1);
    endtask

    task automatic test_full_frame();
        int cyc; bit seen, fd; exp_t e; int p0;
        int         dig [4] = '{1, 2, 5, 9};
        logic [3:0] dv_exp [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b0000};
        rst = 1'b1; tick(1); rst = 1'b0;
        p0 = fd_pulses;
        for (int p = 0; p < 4; p++) begin
            slot(p, seg_of(dig[p], 1'b0), 4'(dig[p]), 6, cyc, seen, fd);
            e = sb.pop_front();
            checks++; if (!seen || cyc != SETTLE) begin failures++; $display("FAIL frame_latency_p%0d: got %0d seen=%0d expected %0d", p, cyc, seen, SETTLE); end
            checks++; if (bus.digits[4*e.pos +: 4] !== e.digit) begin failures++; $display("FAIL frame_digit_p%0d: got %h expected %h", p, bus.digits[4*e.pos +: 4], e.digit); end
            checks++; if (fd !== (p == 3)) begin failures++; $display("FAIL frame_done_p%0d: got %b expected %b", p, fd, (p == 3)); end
            checks++; if (bus.digit_valid !== dv_exp[p]) begin failures++; $display("FAIL frame_valid_p%0d: got %b expected %b", p, bus.digit_valid, dv_exp[p]); end
        end
        go_idle(); tick(2);
        checks++; if (fd_pulses - p0 != 1) begin failures++; $display("FAIL frame_pulses: got %0d expected 1", fd_pulses - p0); end
        checks++; if (bus.digits !== 16'h9521) begin failures++; $display("FAIL frame_digits: got %h expected 9521", bus.digits); end
        checks++; if (bus.dp !== 4'b0000) begin failures++; $display("FAIL frame_dp: got %b expected 0000", bus.dp); end
    endtask

    task automatic test_glitch();
        int cyc; bit s1, s2, s3;
        present(1, seg_of(7, 1'b0));
        wait_capture(SETTLE - 1, cyc, s1);
        bus.seg = 8'hFF;
        wait_capture(2, cyc, s2);
        go_idle();
        wait_capture(3, cyc, s3);
        checks++; if (s1 || s2 || s3) begin failures++; $display("FAIL glitch_capture: got %0d%0d%0d expected 000", s1, s2, s3); end
        checks++; if (bus.digit_valid !== 4'b0000) begin failures++; $display("FAIL glitch_valid: got %b expected 0000", bus.digit_valid); end
        checks++; if (bus.digits !== 16'h9521) begin failures++; $display("FAIL glitch_digits: got %h expected 9521", bus.digits); end
    endtask

    task automatic test_invalid();
        exp_t e;
        present(2, 8'b1111_0000);
        e.pos = 2; e.digit = 4'hE; e.dp_on = 1'b0;
        sb.push_back(e);
        tick(SETTLE - 1);
        checks++; if (bus.err !== 1'b0 || bus.digit_valid !== 4'b0000) begin failures++; $display("FAIL invalid_early: got err=%b valid=%b expected err=0 valid=0000", bus.err, bus.digit_valid); end
        tick(1);
        e = sb.pop_front();
        checks++; if (bus.digits[4*e.pos +: 4] !== e.digit) begin failures++; $display("FAIL invalid_digit: got %h expected %h", bus.digits[4*e.pos +: 4], e.digit); end
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL invalid_err: got %b expected 1", bus.err); end
        checks++; if (bus.digit_valid !== 4'b0100) begin failures++; $display("FAIL invalid_valid: got %b expected 0100", bus.digit_valid); end
        go_idle(); bus.err_clr = 1'b1; tick(1); bus.err_clr = 1'b0;
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL invalid_clear: got %b expected 0", bus.err); end
    endtask

    task automatic test_conflict();
        int cyc; bit seen, fd; exp_t e;
        bus.an = 4'b1100; bus.seg = 8'hFF; bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL conflict_err: got %b expected 1", bus.err); end
        checks++; if (bus.digit_valid !== 4'b0100) begin failures++; $display("FAIL conflict_valid: got %b expected 0100", bus.digit_valid); end
        slot(1, 8'hFF, 4'hF, 4, cyc, seen, fd);
        e = sb.pop_front();
        checks++; if (!seen || cyc != SETTLE) begin failures++; $display("FAIL blank_latency: got %0d seen=%0d expected %0d", cyc, seen, SETTLE); end
        checks++; if (bus.digits[4*e.pos +: 4] !== e.digit) begin failures++; $display("FAIL blank_digit: got %h expected %h", bus.digits[4*e.pos +: 4], e.digit); end
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL blank_err: got %b expected 1", bus.err); end
        checks++; if (bus.digit_valid !== 4'b0110) begin failures++; $display("FAIL blank_valid: got %b expected 0110", bus.digit_valid); end
    endtask

    task automatic test_reset_mid_frame();
        int cyc; bit seen, fd; exp_t e; int p0;
        int         dig [3] = '{0, 6, 7};
        int         pos [3] = '{0, 2, 3};
        logic       dpo [3] = '{1'b1, 1'b0, 1'b1};
        logic [3:0] dv_exp [3] = '{4'b0011, 4'b0111, 4'b0000};
        slot(0, seg_of(4, 1'b0), 4'd4, 5, cyc, seen, fd);
        e = sb.pop_front();
        checks++; if (bus.digits[4*e.pos +: 4] !== e.digit || bus.digit_valid !== 4'b0111) begin failures++; $display("FAIL pre_reset_capture: got %h/%b expected %h/0111", bus.digits[4*e.pos +: 4], bus.digit_valid, e.digit); end
        present(1, seg_of(8, 1'b0));
        tick(2);
        rst = 1'b1; tick(1);
        checks++; if (bus.digits !== 16'hFFFF || bus.dp !== 4'b0000) begin failures++; $display("FAIL midrst_data: got %h/%b expected ffff/0000", bus.digits, bus.dp); end
        checks++; if (bus.digit_valid !== 4'b0000 || bus.frame_done !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b/%b expected 0000/0", bus.digit_valid, bus.frame_done); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL midrst_err: got %b expected 0", bus.err); end
        rst = 1'b0;
        e.pos = 1; e.digit = 4'd8; e.dp_on = 1'b0;
        sb.push_back(e);
        wait_capture(SETTLE + 2, cyc, seen);
        e = sb.pop_front();
        checks++; if (!seen || cyc != SETTLE) begin failures++; $display("FAIL postrst_latency: got %0d seen=%0d expected %0d", cyc, seen, SETTLE); end
        checks++; if (bus.digits[4*e.pos +: 4] !== e.digit || bus.digit_valid !== 4'b0010) begin failures++; $display("FAIL postrst_capture: got %h/%b expected %h/0010", bus.digits[4*e.pos +: 4], bus.digit_valid, e.digit); end
        tick(1);
        p0 = fd_pulses;
        for (int k = 0; k < 3; k++) begin
            slot(pos[k], seg_of(dig[k], dpo[k]), 4'(dig[k]), 5, cyc, seen, fd);
            e = sb.pop_front();
            checks++; if (bus.dp[e.pos] !== e.dp_on || fd !== (k == 2)) begin failures++; $display("FAIL rescan_p%0d: got dp=%b fd=%b expected dp=%b fd=%b", e.pos, bus.dp[e.pos], fd, e.dp_on, (k == 2)); end
            checks++; if (bus.digit_valid !== dv_exp[k]) begin failures++; $display("FAIL rescan_valid_p%0d: got %b expected %b", e.pos, bus.digit_valid, dv_exp[k]); end
        end
        go_idle(); tick(2);
        checks++; if (bus.digits !== 16'h7680 || bus.dp !== 4'b1001) begin failures++; $display("FAIL rescan_frame: got %h/%b expected 7680/1001", bus.digits, bus.dp); end
        checks++; if (fd_pulses - p0 != 1) begin failures++; $display("FAIL rescan_pulses: got %0d expected 1", fd_pulses - p0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_frame();
        test_glitch();
        test_invalid();
        test_conflict();
        test_reset_mid_frame();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_leftover: got %0d expected 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
